pipo_load_arbiter: RTL

Round-robin load arbiter that shares one 16-bit PIPO shift register among NUM_REQ requesters. It drives the PIPO's Enable_In, Load_Data_Signal_In and Parallel_Data_In. It also enforces a minimum hold window so consumers can sample each loaded word. Each requester gets a one-cycle acknowledge once its word is visible on the PIPO output.

---
 rtl/pipo_arb_pkg.sv | 19 +
 rtl/pipo_rr_picker.sv | 40 ++++
 rtl/pipo_load_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipo_arb_pkg.sv
// Shared types and defaults for the PIPO load arbiter.
// Holds the FSM state enum, default parameters and index-width helper.
package pipo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_HOLD_CYCLES = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipo_rr_picker.sv
// Combinational round-robin picker: first request above ptr, with wrap.
// Ports: req (requests), ptr (last grant), winner (index), valid.
module pipo_rr_picker
  import pipo_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] mask;
  logic [2*NUM_REQ-1:0] hit;
  int                   start;

  // Doubling the vector turns the wrap-around scan into a
  // plain lowest-set-bit search inside a window of NUM_REQ bits.
  always_comb begin
    start  = (int'(ptr) + 1) % NUM_REQ;
    dbl    = {req, req};
    mask   = '0;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      mask[i] = (i >= start) && (i < start + NUM_REQ);
    end
    hit    = dbl & mask;
    winner = '0;
    valid  = 1'b0;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (hit[i]) begin
        winner = IW'(i % NUM_REQ);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter sharing one PIPO register among NUM_REQ requesters.
// Ports: Req_In/Req_Data_In in; Grant/Ack/Owner/Busy and Pipo_* out.
module pipo_load_arbiter
  import pipo_arb_pkg::*;
#(
  parameter  int NUM_REQ     = DEF_NUM_REQ,
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int HOLD_CYCLES = DEF_HOLD_CYCLES,
  localparam int IW          = idx_width(NUM_REQ)
) (
  input  logic                          Clk_In,
  input  logic                          Reset_In,
  input  logic [NUM_REQ-1:0]            Req_In,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_In,
  output logic [NUM_REQ-1:0]            Grant_Out,
  output logic [NUM_REQ-1:0]            Ack_Out,
  output logic [IW-1:0]                 Owner_Out,
  output logic                          Busy_Out,
  output logic                          Pipo_Enable_Out,
  output logic                          Pipo_Load_Out,
  output logic [DATA_WIDTH-1:0]         Pipo_Data_Out
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_d, ack_d;
  logic [IW-1:0]           owner_d;
  logic                    busy_d, load_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           win_q, win_d;
  logic [IW-1:0]           pick;
  logic                    pick_valid;

  pipo_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (Req_In),
    .ptr    (ptr_q),
    .winner (pick),
    .valid  (pick_valid)
  );

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q         <= IDLE;
      Grant_Out       <= '0;
      Ack_Out         <= '0;
      Owner_Out       <= '0;
      Busy_Out        <= 1'b0;
      Pipo_Enable_Out <= 1'b0;
      Pipo_Load_Out   <= 1'b0;
      Pipo_Data_Out   <= '0;
      cnt_q           <= '0;
      ptr_q           <= IW'(NUM_REQ - 1);
      win_q           <= '0;
    end else begin
      state_q         <= state_d;
      Grant_Out       <= grant_d;
      Ack_Out         <= ack_d;
      Owner_Out       <= owner_d;
      Busy_Out        <= busy_d;
      Pipo_Enable_Out <= 1'b1;
      Pipo_Load_Out   <= load_d;
      Pipo_Data_Out   <= data_d;
      cnt_q           <= cnt_d;
      ptr_q           <= ptr_d;
      win_q           <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    ack_d   = '0;
    load_d  = 1'b0;
    owner_d = Owner_Out;
    busy_d  = Busy_Out;
    data_d  = Pipo_Data_Out;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            grant_d[i] = (pick == IW'(i));
            if (pick == IW'(i)) begin
              data_d = Req_Data_In[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          load_d  = 1'b1;
          busy_d  = 1'b1;
          win_d   = pick;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // PIPO captures at this edge, so the word is visible
        // on its output during the Ack cycle.
        for (int i = 0; i < NUM_REQ; i++) begin
          ack_d[i] = (win_q == IW'(i));
        end
        owner_d = win_q;
        ptr_d   = win_q;
        cnt_d   = CW'(HOLD_CYCLES - 1);
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
